// File: rtl/osd_stm_eventpkt.sv
`timescale 1ns/1ps
// osd_stm_eventpkt: timestamps CPU trace events, buffers them and emits one DII packet per record.
// Latency: event sampled at edge E -> first flit valid after edge E+2; one idle cycle between packets.
// Backpressure: debug_out holds while !ready; capture never stalls, a full FIFO drops and counts events.
module osd_stm_eventpkt #(
  parameter int VALWIDTH  = 64,
  parameter int BUF_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [9:0]          id,
  input  logic [9:0]          event_dest,
  input  logic                enable,
  input  logic                trace_valid,
  input  logic [15:0]         trace_id,
  input  logic [VALWIDTH-1:0] trace_value,
  output logic [17:0]         debug_out,       // {valid, last, data[15:0]}
  input  logic                debug_out_ready
);
  localparam int NW      = VALWIDTH / 16;
  localparam int EVT_LEN = 6 + NW;
  localparam int AW      = $clog2(BUF_DEPTH);
  localparam int CW      = AW + 1;
  localparam int IW      = $clog2(EVT_LEN);

  // Overflow records reuse the tid field for the drop count.
  typedef struct packed {
    logic                is_ovf;
    logic [31:0]         ts;
    logic [15:0]         tid;
    logic [VALWIDTH-1:0] val;
  } rec_t;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  logic                r_in_vld;
  logic [15:0]         r_in_id;
  logic [VALWIDTH-1:0] r_in_val;
  logic [31:0]         r_ts;
  logic [15:0]         r_ovf;
  rec_t                r_mem [BUF_DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [CW-1:0]       r_cnt;
  state_t              r_state;
  logic [IW-1:0]       r_idx;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  rec_t                w_rec;
  logic [15:0]         w_ovf_nxt;
  rec_t                w_head;
  logic [IW-1:0]       w_len;
  logic                w_last;
  logic [15:0]         w_data;
  logic                w_valid;
  logic                w_pop;
  state_t              w_state_nxt;
  logic [IW-1:0]       w_idx_nxt;

  // Fullness is taken from the registered count, so a same-cycle pop frees nothing yet.
  assign w_full  = (r_cnt == CW'(BUF_DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_head  = r_mem[r_rptr];

  // Trace port is registered once; enable gates events at the sampling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_vld <= 1'b0;
      r_in_id  <= '0;
      r_in_val <= '0;
    end else begin
      r_in_vld <= trace_valid & enable;
      r_in_id  <= trace_id;
      r_in_val <= trace_value;
    end
  end

  // Free-running timestamp, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) r_ts <= '0;
    else     r_ts <= r_ts + 32'd1;
  end

  // Capture decision: a pending drop count is flushed before any new event is stored.
  always_comb begin
    w_push    = 1'b0;
    w_rec     = '0;
    w_ovf_nxt = r_ovf;
    if (!w_full) begin
      if (r_ovf != 16'h0) begin
        w_push     = 1'b1;
        w_rec.is_ovf = 1'b1;
        w_rec.ts   = r_ts;
        w_rec.tid  = r_ovf;
        w_ovf_nxt  = r_in_vld ? 16'h0001 : 16'h0000;
      end else if (r_in_vld) begin
        w_push    = 1'b1;
        w_rec.ts  = r_ts;
        w_rec.tid = r_in_id;
        w_rec.val = r_in_val;
      end
    end else if (r_in_vld && r_ovf != 16'hFFFF) begin
      w_ovf_nxt = r_ovf + 16'h0001;
    end
  end

  // Drop counter and FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      r_ovf <= w_ovf_nxt;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // FIFO storage; contents are meaningless until the count says otherwise.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_rec;
  end

  // Flit selection from the head record and the flit index.
  always_comb begin
    w_len  = w_head.is_ovf ? IW'(6) : IW'(EVT_LEN);
    w_last = (r_idx == w_len - 1'b1);
    w_data = 16'h0000;
    case (r_idx)
      IW'(0): w_data = {6'b0, event_dest};
      IW'(1): w_data = {6'b0, id};
      IW'(2): w_data = w_head.is_ovf ? 16'h8400 : 16'h8000;
      IW'(3): w_data = w_head.ts[15:0];
      IW'(4): w_data = w_head.ts[31:16];
      IW'(5): w_data = w_head.tid;
      default: begin
        for (int k = 0; k < NW; k++) begin
          if (r_idx == IW'(6 + k)) w_data = w_head.val[16*k +: 16];
        end
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // FSM next state: IDLE always costs one cycle, which gives the inter-packet bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pop       = 1'b0;
    w_valid     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = S_SEND;
          w_idx_nxt   = '0;
        end
      end
      S_SEND: begin
        w_valid = 1'b1;
        if (debug_out_ready) begin
          if (w_last) begin
            w_pop       = 1'b1;
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
    endcase
  end

  assign debug_out = {w_valid, w_valid & w_last, w_valid ? w_data : 16'h0000};

endmodule
